diff_deser_rx: RTL
==================

Name: diff_deser_rx

Overview:
Receive-side counterpart to the team's XOR-accumulate differential line encoder. The block:
- recovers data bits from the line as decoded = line ^ previous line bit;
- hunts for a sync word in the decoded stream;
- assembles FRAME_WORDS words of WIDTH bits, MSB first;
- presents each word on a valid/ready output port.

It sits between the serial line sampler and the word-level consumer logic.

Parameters:
WIDTH, 8, bits per word and sync word length (min 2)
SYNC_WORD, 8'hA5, decoded pattern that opens a frame (WIDTH bits)
FRAME_WORDS, 4, data words per frame after sync (min 1)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
rx_bit  input  1  encoded line bit
rx_valid  input  1  strobe; rx_bit is sampled only when high
data_out  output  WIDTH  assembled word, MSB = first received bit
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts the word when data_valid && data_ready
locked  output  1  high while in LOCKED (or PARITY) state
overrun  output  1  one-cycle pulse: word completed while the output register was still full
parity_err  output  1  parity result qualified by data_valid; tied 0 when the feature is compiled out

Behaviour:
- Reset values: prev_line=0, shift register=0, bit_cnt=0, word_cnt=0, state=HUNT, data_out=0, data_valid=0, locked=0, overrun=0, parity_err=0.
- Decode, only on rx_valid cycles:
  - d = rx_bit ^ prev_line;
  - prev_line <= rx_bit.
  - With no rx_valid, all state holds.
- HUNT:
  - On each rx_valid, shift d into a WIDTH-bit window (shift left, d enters at LSB).
  - If the updated window == SYNC_WORD, go to LOCKED with bit_cnt=0 and word_cnt=0.
  - The sync word itself is never output.
- LOCKED:
  - On each rx_valid, shift d into the word register and increment bit_cnt.
  - The rx_valid with bit_cnt==WIDTH-1 completes the word.
  - Load the output register on the next edge: data_valid=1 on the cycle after that rx_valid (latency 1 clk).
  - Reset bit_cnt to 0 and increment word_cnt.
  - If the completed word was word FRAME_WORDS-1, go to HUNT and clear the sync window to 0. Back-to-back frames therefore need a fresh full sync word.
- Output handshake:
  - data_valid stays high until data_valid && data_ready.
  - On acceptance, data_valid drops next cycle unless a new word completes in that same cycle. In that case the new word loads and data_valid stays 1; this is not an overrun.
- Overrun:
  - Raised when a word completes while data_valid=1 and data_ready=0.
  - The new word is dropped, the held word is unchanged, and overrun pulses high for one cycle.
  - Frame counting continues.
- locked=1 exactly while state != HUNT.
- Reset mid-frame: returns immediately to reset values. Any partial word is lost and a held output word is discarded.
- prev_line continues tracking in every state, so decoding is never interrupted by state changes.

Optional Feature:
- Macro: DIFF_DESER_PARITY_EN.
- When defined:
  - After each word's last bit, the FSM enters state PARITY and consumes one extra decoded bit p.
  - The word is loaded into the output register on the edge following the p bit.
  - parity_err is loaded with (^word) ^ p, so even parity is expected and 0 means pass.
  - The frame-end check (return to HUNT) occurs after the parity bit of the last word.
  - Overrun rules apply at that load point.
- When undefined:
  - There is no PARITY state and words load as above.
  - parity_err is constant 0.

Decomposition:
- Package diff_deser_pkg:
  - state enum {HUNT, LOCKED, PARITY}; PARITY is defined even when unused;
  - default WIDTH, SYNC_WORD and FRAME_WORDS constants;
  - cnt-width helper constants ($clog2).
- Sub-module diff_bit_decode:
  - holds the prev_line register;
  - ports clk, reset, rx_bit, rx_valid, d, d_valid;
  - d_valid = rx_valid, combinational;
  - instantiated once.

Test Plan:
- Reset, then line bits 1,1,0,0,0,1,1,0 with one rx_valid per bit. This decodes to A5 -> locked=1 on the cycle after the 8th strobe; data_valid stays 0.
- After lock, feed encoded bytes 0x3C,0xFF,0x00,0x81 with data_ready=1 -> four data_valid pulses, each one cycle after the last bit, with data_out in that order; then locked=0.
- Hold data_ready=0 through words 1 and 2 -> data_out stays 0x3C, overrun pulses once when 0xFF completes, and data_valid stays 1.
- Assert reset after 3 bits of word 2 -> all outputs are 0 next cycle; a new sync is required before any output.
- Gap rx_valid with random idle cycles between bits of 0xA5 plus 0x12 -> output is identical to the gapless case.
- With DIFF_DESER_PARITY_EN: send 0x03 with p=0 -> parity_err=0; send 0x07 with p=0 -> parity_err=1.

Source files
------------

// File: rtl/diff_deser_pkg.sv
// diff_deser_pkg: shared FSM state type, default parameters and counter-width helper
package diff_deser_pkg;
    typedef enum logic [1:0] {HUNT, LOCKED, PARITY} state_t;
    localparam int DEF_WIDTH = 8;
    localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
    localparam int DEF_FRAME_WORDS = 4;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEF_BIT_CW = cnt_w(DEF_WIDTH);
    localparam int DEF_WORD_CW = cnt_w(DEF_FRAME_WORDS);
endpackage

// File: rtl/diff_bit_decode.sv
// diff_bit_decode: undoes the XOR-accumulate line code, one bit per rx_valid strobe
module diff_bit_decode (
    input  logic clk,
    input  logic reset,
    input  logic rx_bit,
    input  logic rx_valid,
    output logic d,
    output logic d_valid
);
    logic prev_line;
    // track the last sampled line bit regardless of what the framer is doing
    always_ff @(posedge clk or posedge reset)
        if (reset) prev_line <= 1'b0;
        else if (rx_valid) prev_line <= rx_bit;
    assign d = rx_bit ^ prev_line;
    assign d_valid = rx_valid;
endmodule

// File: rtl/diff_deser_rx.sv
// diff_deser_rx: sync hunt + word framer with valid/ready output; DIFF_DESER_PARITY_EN adds a per-word even-parity bit
module diff_deser_rx
    import diff_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEF_SYNC_WORD),
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_bit,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             locked,
    output logic             overrun,
    output logic             parity_err
);
    localparam int BCW = cnt_w(WIDTH);
    localparam int WCW = cnt_w(FRAME_WORDS);
`ifdef DIFF_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    state_t state, state_n;
    logic [WIDTH-1:0] shreg, sh_next, word;
    logic [BCW-1:0] bit_cnt;
    logic [WCW-1:0] word_cnt;
    logic d, d_valid, bit_last, word_last, load, take, frame_end;

    diff_bit_decode u_dec (
        .clk(clk),
        .reset(reset),
        .rx_bit(rx_bit),
        .rx_valid(rx_valid),
        .d(d),
        .d_valid(d_valid)
    );

    // one register serves as sync window while hunting and as word register while locked
    assign sh_next = {shreg[WIDTH-2:0], d};
    assign bit_last = bit_cnt == BCW'(WIDTH - 1);
    assign word_last = word_cnt == WCW'(FRAME_WORDS - 1);
    assign load = d_valid && (PAR_EN ? state == PARITY : state == LOCKED && bit_last);
    assign word = PAR_EN ? shreg : sh_next;
    assign take = load && (!data_valid || data_ready);
    assign frame_end = load && word_last;

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= HUNT;
        else state <= state_n;

    // next-state: lock on sync match, detour through PARITY when enabled, drop out after the last word
    always_comb
        state_n = !d_valid ? state :
                  state == HUNT ? (sh_next == SYNC_WORD ? LOCKED : HUNT) :
                  frame_end ? HUNT :
                  (state == LOCKED && bit_last && PAR_EN) ? PARITY :
                  state == PARITY ? LOCKED : state;

    // outputs decoded from state
    always_comb
        locked = state != HUNT;

    // shift window/word, bit and word counters; window is cleared at frame end so a fresh sync is needed
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            shreg <= '0;
            bit_cnt <= '0;
            word_cnt <= '0;
        end else if (d_valid) begin
            shreg <= frame_end ? '0 : state == PARITY ? shreg : sh_next;
            bit_cnt <= (state != LOCKED || bit_last) ? '0 : bit_cnt + 1'b1;
            word_cnt <= state == HUNT ? '0 : load ? word_cnt + 1'b1 : word_cnt;
        end

    // output register: load when empty or being drained, otherwise drop the new word and flag overrun
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_out <= '0;
            data_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= load && data_valid && !data_ready;
            if (take) begin
                data_out <= word;
                data_valid <= 1'b1;
            end else if (data_ready) data_valid <= 1'b0;
        end

`ifdef DIFF_DESER_PARITY_EN
    logic perr;
    // parity verdict travels with the word it was computed for
    always_ff @(posedge clk or posedge reset)
        if (reset) perr <= 1'b0;
        else if (take) perr <= (^shreg) ^ d;
    assign parity_err = perr & data_valid;
`else
    assign parity_err = 1'b0;
`endif
endmodule
